// File: rtl/ac_stim.sv
// ---------------------------------------------------------------------------
// ac_stim : self-checking stimulus generator for an 8-bit-in / 16-bit-sum
//           registered accumulator.
//
// A run resets the accumulator for two cycles. It then drives `count`
// samples, which are either an 8-bit LFSR sequence or a constant. While it
// drives, it keeps its own reference sum. It compares the accumulator's sum
// against that reference on every drive cycle and once more in a drain cycle.
// At the end of the run it pulses `done` and reports pass/fail.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous reset, active low
//   start      begin a run (only honoured in IDLE)
//   mode       0 = LFSR stimulus, 1 = constant stimulus (captured at start)
//   seed       LFSR seed / constant value             (captured at start)
//   count      number of drive samples, 0..255         (captured at start)
//   ac_in      stimulus to accumulator input
//   ac_rst     accumulator reset, active high
//   ac_sum     accumulator sum (observed)
//   busy       high in DUT_RST, DRIVE, DRAIN
//   done       one-cycle pulse in the DONE state
//   pass       err_cnt == 0 at end of run; held until the next start
//   err_cnt    compare mismatches, saturating at 255
//   first_err  compare index of the first mismatch, 8'hFF if none
//   exp_sum    reference-model sum
// ---------------------------------------------------------------------------
module ac_stim (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [7:0]  seed,
    input  logic [7:0]  count,
    output logic [7:0]  ac_in,
    output logic        ac_rst,
    input  logic [15:0] ac_sum,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_cnt,
    output logic [7:0]  first_err,
    output logic [15:0] exp_sum
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DUT_RST = 3'd1,
        S_DRIVE   = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Run configuration latched on an accepted start.
    typedef struct packed {
        logic       mode;
        logic [7:0] seed;
        logic [7:0] count;
    } cfg_t;

    state_t     state;
    state_t     state_nx;
    cfg_t       cfg;

    logic [7:0] lfsr;
    logic [7:0] lfsr_nx;
    logic [7:0] idx;        // drive index; equals count during DRAIN
    logic       rst_phase;  // 0 = first DUT_RST cycle, 1 = second
    logic       in_rst;     // set while block reset is being applied

    logic       accept;
    logic       drv_last;
    logic       cmp_en;
    logic       mismatch;
    logic [7:0] err_nx;

    assign accept   = (state == S_IDLE) && start;
    assign drv_last = (idx == (cfg.count - 8'd1));
    assign cmp_en   = (state == S_DRIVE) || (state == S_DRAIN);

    // Case inequality: an X/Z on any bit of ac_sum counts as a mismatch
    // in simulation. Synthesis reduces this to a plain inequality.
    assign mismatch = (ac_sum !== exp_sum);

    // x^8 + x^6 + x^5 + x^4 + 1, left shift, feedback into bit 0.
    assign lfsr_nx  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Saturating error count including this cycle's compare. The DRAIN edge
    // uses it so that pass also covers the final compare.
    always_comb begin
        err_nx = err_cnt;
        if (cmp_en && mismatch && (err_cnt != 8'hFF))
            err_nx = err_cnt + 8'd1;
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_DUT_RST;
            S_DUT_RST: if (rst_phase)
                           state_nx = (cfg.count == 8'd0) ? S_DRAIN : S_DRIVE;
            S_DRIVE:   if (drv_last) state_nx = S_DRAIN;
            S_DRAIN:   state_nx = S_DONE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy   = (state == S_DUT_RST) || (state == S_DRIVE) || (state == S_DRAIN);
        done   = (state == S_DONE);
        // The accumulator stays in reset while this block is in reset.
        // It is released on the first IDLE cycle after rst goes high.
        ac_rst = in_rst || (state == S_DUT_RST);
        ac_in  = 8'h00;
        if (state == S_DRIVE)
            ac_in = cfg.mode ? cfg.seed : lfsr;
    end

    // ---------------- datapath / reference model ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_rst    <= 1'b1;
            cfg       <= '0;
            lfsr      <= 8'h01;
            idx       <= 8'h00;
            rst_phase <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= 8'h00;
            first_err <= 8'hFF;
            exp_sum   <= 16'h0000;
        end else begin
            in_rst <= 1'b0;
            if (accept) begin
                cfg       <= {mode, seed, count};
                // An all-zero LFSR would lock up, so seed 0 starts at 1.
                lfsr      <= (seed == 8'h00) ? 8'h01 : seed;
                idx       <= 8'h00;
                rst_phase <= 1'b0;
                pass      <= 1'b0;
                err_cnt   <= 8'h00;
                first_err <= 8'hFF;
                exp_sum   <= 16'h0000;
            end else begin
                if (state == S_DUT_RST)
                    rst_phase <= 1'b1;

                if (state == S_DRIVE) begin
                    lfsr    <= lfsr_nx;
                    idx     <= idx + 8'd1;
                    exp_sum <= exp_sum + {8'h00, ac_in};
                end

                if (cmp_en) begin
                    err_cnt <= err_nx;
                    // err_cnt saturates and never returns to zero,
                    // so zero means no mismatch has happened yet.
                    if (mismatch && (err_cnt == 8'h00))
                        first_err <= idx;
                end

                if (state == S_DRAIN)
                    pass <= (err_nx == 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_ac_stim.sv
// Bench for ac_stim. A simple registered accumulator sits in the bench. It
// can be forced to read zero, which gives a stuck-sum fault. Each run's
// expected stimulus, sums and error record come from arrays that the bench
// builds from the LFSR polynomial and plain arithmetic.
module tb_ac_stim;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic [7:0]  count = 8'h00;
    logic [7:0]  ac_in;
    logic        ac_rst;
    logic [15:0] ac_sum;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  err_cnt;
    logic [7:0]  first_err;
    logic [15:0] exp_sum;

    int n_chk  = 0;
    int n_fail = 0;

    logic        stuck = 1'b0;
    logic [15:0] acc   = 16'h0000;

    always #5 clk = ~clk;

    // Accumulator under test: sum_next = sum + in, sync active-high reset.
    always @(posedge clk) begin
        if (ac_rst) acc <= 16'h0000;
        else        acc <= acc + {8'h00, ac_in};
    end
    assign ac_sum = stuck ? 16'h0000 : acc;

    ac_stim dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .count(count), .ac_in(ac_in), .ac_rst(ac_rst), .ac_sum(ac_sum),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err(first_err), .exp_sum(exp_sum)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One LFSR step of x^8+x^6+x^5+x^4+1: shift left. The new bit 0 is the
    // parity of state bits 7,5,4,3 (mask 0xB8).
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        int v;
        v = (int'(s) * 2) % 256 + int'(^(s & 8'hB8));
        return 8'(v);
    endfunction

    task automatic reset_vals(input string pfx);
        chk({pfx, "_ac_in"},     32'(ac_in),     32'h0);
        chk({pfx, "_ac_rst"},    32'(ac_rst),    32'h1);
        chk({pfx, "_busy"},      32'(busy),      32'h0);
        chk({pfx, "_done"},      32'(done),      32'h0);
        chk({pfx, "_pass"},      32'(pass),      32'h0);
        chk({pfx, "_err_cnt"},   32'(err_cnt),   32'h0);
        chk({pfx, "_first_err"}, 32'(first_err), 32'hFF);
        chk({pfx, "_exp_sum"},   32'(exp_sum),   32'h0);
    endtask

    // One run. flt=1 makes the sum read as zero. poke_c pulses start in
    // cycle poke_c (2..count+3, 0=never). abort_c asserts rst in cycle
    // abort_c (0=never).
    task automatic run(input logic m, input logic [7:0] sd, input logic [7:0] cnt,
                       input logic flt, input int poke_c, input int abort_c);
        logic [7:0]  ins [256];
        logic [15:0] sums[257];
        bit          mm  [257];
        bit          seen[256];
        logic [7:0]  s;
        int n, errs, first, busy_n, reps, i;
        n = int'(cnt);
        s = (sd == 8'h00) ? 8'h01 : sd;
        sums[0] = 16'h0000;
        for (int k = 0; k < n; k++) begin
            ins[k]    = m ? sd : s;
            s         = lfsr_step(s);
            sums[k+1] = sums[k] + {8'h00, ins[k]};
        end
        for (int k = 0; k <= n; k++) mm[k] = flt && (sums[k] != 16'h0000);
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        errs = 0; first = 255; busy_n = 0; reps = 0;
        stuck = flt;

        @(negedge clk);
        start = 1'b1; mode = m; seed = sd; count = cnt;
        for (int c = 1; c <= n + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                mode  = 1'($urandom);
                seed  = 8'($urandom);
                count = 8'($urandom);
            end
            if (poke_c != 0 && c == poke_c)     start = 1'b1;
            if (poke_c != 0 && c == poke_c + 1) start = 1'b0;
            if (busy) busy_n++;

            if (c <= 2) begin
                chk("dutrst_ac_rst", 32'(ac_rst), 32'h1);
                chk("dutrst_ac_in",  32'(ac_in),  32'h0);
                chk("dutrst_exp",    32'(exp_sum), 32'h0);
                chk("dutrst_busy",   32'(busy),   32'h1);
                if (c == 1) begin
                    chk("start_pass_clr",  32'(pass),      32'h0);
                    chk("start_err_clr",   32'(err_cnt),   32'h0);
                    chk("start_first_clr", 32'(first_err), 32'hFF);
                end
            end else if (c <= n + 2) begin
                i = c - 3;
                chk("drive_ac_in",  32'(ac_in),   32'(ins[i]));
                chk("drive_ac_rst", 32'(ac_rst),  32'h0);
                chk("drive_exp",    32'(exp_sum), 32'(sums[i]));
                chk("drive_err",    32'(err_cnt), 32'(errs));
                chk("drive_busy",   32'(busy),    32'h1);
                chk("drive_done",   32'(done),    32'h0);
                if (seen[ac_in]) reps++;
                seen[ac_in] = 1'b1;
            end else if (c == n + 3) begin
                chk("drain_ac_in",  32'(ac_in),   32'h0);
                chk("drain_ac_rst", 32'(ac_rst),  32'h0);
                chk("drain_exp",    32'(exp_sum), 32'(sums[n]));
                chk("drain_err",    32'(err_cnt), 32'(errs));
                chk("drain_busy",   32'(busy),    32'h1);
            end else begin
                chk("done_pulse", 32'(done),      32'h1);
                chk("done_busy",  32'(busy),      32'h0);
                chk("done_pass",  32'(pass),      32'(errs == 0));
                chk("done_err",   32'(err_cnt),   32'(errs));
                chk("done_first", 32'(first_err), 32'(first));
                chk("done_exp",   32'(exp_sum),   32'(sums[n]));
            end

            if (abort_c != 0 && c == abort_c) begin
                start = 1'b0;
                rst   = 1'b0;
                @(negedge clk);
                reset_vals("abort");
                @(negedge clk);
                chk("abort_hold_ac_rst", 32'(ac_rst), 32'h1);
                rst = 1'b1;
                @(negedge clk);
                chk("abort_rel_ac_rst", 32'(ac_rst), 32'h0);
                chk("abort_rel_busy",   32'(busy),   32'h0);
                return;
            end

            // Account for the compare made in this cycle at index c-3.
            if (c >= 3 && c <= n + 3 && mm[c-3]) begin
                if (errs == 0) first = c - 3;
                if (errs < 255) errs++;
            end
        end

        chk("busy_cycles", 32'(busy_n), 32'(n + 3));
        if (m == 1'b0 && n == 255) chk("lfsr_norep", 32'(reps), 32'h0);

        // Results hold in IDLE.
        @(negedge clk);
        chk("idle_done",   32'(done),      32'h0);
        chk("idle_busy",   32'(busy),      32'h0);
        chk("idle_ac_in",  32'(ac_in),     32'h0);
        chk("idle_ac_rst", 32'(ac_rst),    32'h0);
        chk("idle_pass",   32'(pass),      32'(errs == 0));
        chk("idle_err",    32'(err_cnt),   32'(errs));
        chk("idle_first",  32'(first_err), 32'(first));
        chk("idle_exp",    32'(exp_sum),   32'(sums[n]));
    endtask

    initial begin
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_vals("por");
        rst = 1'b1;
        @(negedge clk);
        chk("por_rel_ac_rst", 32'(ac_rst), 32'h0);

        // count = 0: straight from DUT_RST to DRAIN
        run(1'b1, 8'h5A, 8'd0, 1'b0, 0, 0);
        chk("cnt0_first", 32'(first_err), 32'hFF);

        // constant FF x 255
        run(1'b1, 8'hFF, 8'd255, 1'b0, 0, 0);
        chk("sum_ff_255", 32'(exp_sum), 32'hFE01);
        chk("pass_ff_255", 32'(pass), 32'h1);

        // stuck-at-zero sum
        run(1'b1, 8'h01, 8'd4, 1'b1, 0, 0);
        chk("stuck_err", 32'(err_cnt), 32'h4);
        chk("stuck_first", 32'(first_err), 32'h1);
        chk("stuck_pass", 32'(pass), 32'h0);

        // seed 0 with LFSR: full period, first sample 01
        run(1'b0, 8'h00, 8'd255, 1'b0, 0, 0);

        // reset abort at drive index 3, then a clean run
        run(1'b0, 8'h33, 8'd10, 1'b0, 0, 6);
        run(1'b0, 8'h33, 8'd10, 1'b0, 0, 0);
        chk("after_abort_pass", 32'(pass), 32'h1);

        // start pulses while busy are ignored
        run(1'b1, 8'h07, 8'd6, 1'b0, 4, 0);
        run(1'b0, 8'h9C, 8'd3, 1'b0, 2, 0);

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            logic       rm, rf;
            logic [7:0] rs, rc;
            int         rp;
            rm = 1'($urandom_range(0, 1));
            rs = 8'($urandom);
            rc = 8'($urandom_range(0, 40));
            rf = ($urandom_range(0, 3) == 0);
            rp = ($urandom_range(0, 1) == 1) ? $urandom_range(2, int'(rc) + 3) : 0;
            run(rm, rs, rc, rf, rp, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
